// File: rtl/addr_seq_pkg.sv
// Shared constants and state encoding for the AES address sequencers.
package aes_addr_pkg;

    localparam int ADDR_WIDTH_DEF = 8;
    localparam int CNT_WIDTH_DEF  = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/addr_seq_if.sv
// Control and memory-side bundle between the AES control FSM and addr_seq.
interface addr_seq_if
    import aes_addr_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) ();

    logic                  enable_i;
    logic                  start_i;
    logic [ADDR_WIDTH-1:0] base_i;
    logic [CNT_WIDTH-1:0]  count_i;
    logic [ADDR_WIDTH-1:0] wrap_lo_i;
    logic [ADDR_WIDTH-1:0] wrap_hi_i;
    logic                  abort_i;
    logic                  ready_i;
    logic [ADDR_WIDTH-1:0] addr_o;
    logic                  valid_o;
    logic                  last_o;
    logic                  busy_o;
    logic                  done_o;

    modport master (
        output enable_i, start_i, base_i, count_i, wrap_lo_i, wrap_hi_i, abort_i, ready_i,
        input  addr_o, valid_o, last_o, busy_o, done_o
    );

    modport slave (
        input  enable_i, start_i, base_i, count_i, wrap_lo_i, wrap_hi_i, abort_i, ready_i,
        output addr_o, valid_o, last_o, busy_o, done_o
    );

endinterface

// File: rtl/addr_seq_step.sv
// Next-address generator: addr + STRIDE, optionally folded back into [wrap_lo, wrap_hi].
module addr_step
    import aes_addr_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int STRIDE     = 1
) (
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic                  i_wrap_en,
    input  logic [ADDR_WIDTH-1:0] i_wrap_lo,
    input  logic [ADDR_WIDTH-1:0] i_wrap_hi,
    output logic [ADDR_WIDTH-1:0] o_next
);

    localparam logic [ADDR_WIDTH:0] STEP = (ADDR_WIDTH+1)'(STRIDE);

    logic [ADDR_WIDTH:0] w_sum;

    // The extra carry bit keeps a step past the top of the address space above wrap_hi.
    always_comb begin
        w_sum  = {1'b0, i_addr} + STEP;
        o_next = w_sum[ADDR_WIDTH-1:0];
        if (i_wrap_en && (w_sum > {1'b0, i_wrap_hi})) begin
            o_next = i_wrap_lo;
        end
    end

endmodule

// File: rtl/addr_seq.sv
// Address sequencer for AES key ROM / state RAM: free-run increment or windowed bursts.
//   state   | meaning
//   ST_IDLE | free-run increment on enable_i, waiting for start_i
//   ST_RUN  | presenting burst beats, advancing on valid_o & ready_i
//   ST_DONE | single-cycle done_o pulse, then back to ST_IDLE
module addr_seq
    import aes_addr_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int CNT_WIDTH  = CNT_WIDTH_DEF,
    parameter int STRIDE     = 1
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    addr_seq_if.slave  bus
);

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [CNT_WIDTH-1:0]  r_remaining;
    logic                  r_valid;
    logic                  r_last;
    logic                  r_busy;
    logic                  r_done;

    logic                  w_wrap_en;
    logic [ADDR_WIDTH-1:0] w_next;

    // One stepper serves both paths; the window only applies to burst beats.
    assign w_wrap_en = (r_state == ST_RUN);

    addr_step #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .STRIDE     (STRIDE)
    ) u_step (
        .i_addr    (r_addr),
        .i_wrap_en (w_wrap_en),
        .i_wrap_lo (bus.wrap_lo_i),
        .i_wrap_hi (bus.wrap_hi_i),
        .o_next    (w_next)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state     <= ST_IDLE;
            r_addr      <= {ADDR_WIDTH{1'b1}};
            r_remaining <= '0;
            r_valid     <= 1'b0;
            r_last      <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (bus.start_i) begin
                        r_busy <= 1'b1;
                        if (bus.count_i != '0) begin
                            r_state     <= ST_RUN;
                            r_addr      <= bus.base_i;
                            r_remaining <= bus.count_i;
                            r_valid     <= 1'b1;
                            r_last      <= (bus.count_i == CNT_WIDTH'(1));
                        end else begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end
                    end else if (bus.enable_i) begin
                        r_addr <= w_next;
                    end
                end
                ST_RUN: begin
                    // Abort wins over a coincident beat; no further address is issued.
                    if (bus.abort_i || (bus.ready_i && r_last)) begin
                        r_state     <= ST_DONE;
                        r_remaining <= '0;
                        r_valid     <= 1'b0;
                        r_last      <= 1'b0;
                        r_done      <= 1'b1;
                    end else if (bus.ready_i) begin
                        r_addr      <= w_next;
                        r_remaining <= r_remaining - CNT_WIDTH'(1);
                        r_last      <= (r_remaining == CNT_WIDTH'(2));
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_valid <= 1'b0;
                    r_last  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.addr_o  = r_addr;
    assign bus.valid_o = r_valid;
    assign bus.last_o  = r_last;
    assign bus.busy_o  = r_busy;
    assign bus.done_o  = r_done;

endmodule

// File: tb/tb_addr_seq.sv
// Bench for addr_seq: directed vector table, a STRIDE=4 windowed burst, and random traffic vs. a burst-list model.
module tb_addr_seq;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    addr_seq_if #(.ADDR_WIDTH(8), .CNT_WIDTH(5)) if1 ();
    addr_seq_if #(.ADDR_WIDTH(8), .CNT_WIDTH(5)) if4 ();

    addr_seq #(.ADDR_WIDTH(8), .CNT_WIDTH(5), .STRIDE(1)) dut1 (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (if1)
    );

    addr_seq #(.ADDR_WIDTH(8), .CNT_WIDTH(5), .STRIDE(4)) dut4 (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (if4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic       en;
        logic       st;
        logic [7:0] base;
        logic [4:0] cnt;
        logic       rdy;
        logic       abt;
        logic [7:0] e_addr;
        logic       e_valid;
        logic       e_last;
        logic       e_busy;
        logic       e_done;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic en, input logic st,
                                input logic [7:0] base, input logic [4:0] cnt,
                                input logic rdy, input logic abt,
                                input logic [7:0] ea, input logic ev, input logic el,
                                input logic eb, input logic ed);
        vec_t v;
        v.rst_n = r;   v.en = en;   v.st = st;  v.base = base; v.cnt = cnt;
        v.rdy = rdy;   v.abt = abt; v.e_addr = ea; v.e_valid = ev;
        v.e_last = el; v.e_busy = eb; v.e_done = ed;
        return v;
    endfunction

    // Reference model for dut1: a burst is the precomputed list of addresses still to issue.
    logic [7:0] m_addr;
    int         mq[$];
    bit         m_done;

    task automatic model_update();
        int a;
        if (!rst_n) begin
            m_addr = 8'hFF;
            mq.delete();
            m_done = 1'b0;
        end else if (m_done) begin
            m_done = 1'b0;
        end else if (mq.size() != 0) begin
            if (if1.abort_i || (if1.ready_i && mq.size() == 1)) begin
                m_addr = 8'(mq[0]);
                mq.delete();
                m_done = 1'b1;
            end else if (if1.ready_i) begin
                void'(mq.pop_front());
            end
        end else if (if1.start_i) begin
            if (if1.count_i == 5'd0) begin
                m_done = 1'b1;
            end else begin
                a = int'(if1.base_i);
                for (int i = 0; i < int'(if1.count_i); i++) begin
                    mq.push_back(a);
                    if (a + 1 > int'(if1.wrap_hi_i)) a = int'(if1.wrap_lo_i);
                    else a = a + 1;
                end
            end
        end else if (if1.enable_i) begin
            m_addr = m_addr + 8'd1;
        end
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic drive1(input vec_t v);
        rst_n        = v.rst_n;
        if1.enable_i = v.en;
        if1.start_i  = v.st;
        if1.base_i   = v.base;
        if1.count_i  = v.cnt;
        if1.ready_i  = v.rdy;
        if1.abort_i  = v.abt;
    endtask

    task automatic check_model(input string tag);
        chk({tag, " addr"},  int'(if1.addr_o),  (mq.size() != 0) ? mq[0] : int'(m_addr));
        chk({tag, " valid"}, int'(if1.valid_o), int'(mq.size() != 0));
        chk({tag, " last"},  int'(if1.last_o),  int'(mq.size() == 1));
        chk({tag, " busy"},  int'(if1.busy_o),  int'(mq.size() != 0 || m_done));
        chk({tag, " done"},  int'(if1.done_o),  int'(m_done));
    endtask

    logic [7:0] s4_addr [6];
    logic       s4_flags [6][4];
    int         done_cnt;

    initial begin
        checks = 0;
        errors = 0;
        m_addr = 8'hFF;
        m_done = 1'b0;
        rst_n  = 1'b0;
        if1.enable_i = 0; if1.start_i = 0; if1.base_i = 0; if1.count_i = 0;
        if1.abort_i = 0;  if1.ready_i = 0; if1.wrap_lo_i = 8'h00; if1.wrap_hi_i = 8'hFF;
        if4.enable_i = 0; if4.start_i = 0; if4.base_i = 0; if4.count_i = 0;
        if4.abort_i = 0;  if4.ready_i = 0; if4.wrap_lo_i = 8'h20; if4.wrap_hi_i = 8'h2F;

        // reset then free-run
        vecs.push_back(mk(0,0,0,8'h00,5'd0,0,0, 8'hFF,0,0,0,0));
        vecs.push_back(mk(1,1,0,8'h00,5'd0,0,0, 8'h00,0,0,0,0));
        vecs.push_back(mk(1,1,0,8'h00,5'd0,0,0, 8'h01,0,0,0,0));
        vecs.push_back(mk(1,1,0,8'h00,5'd0,0,0, 8'h02,0,0,0,0));
        // 4-beat burst from 0x10
        vecs.push_back(mk(1,0,1,8'h10,5'd4,1,0, 8'h10,1,0,1,0));
        vecs.push_back(mk(1,0,0,8'h00,5'd0,1,0, 8'h11,1,0,1,0));
        vecs.push_back(mk(1,0,0,8'h00,5'd0,1,0, 8'h12,1,0,1,0));
        vecs.push_back(mk(1,0,0,8'h00,5'd0,1,0, 8'h13,1,1,1,0));
        vecs.push_back(mk(1,0,0,8'h00,5'd0,1,0, 8'h13,0,0,1,1));
        vecs.push_back(mk(1,0,0,8'h00,5'd0,1,0, 8'h13,0,0,0,0));
        // empty burst
        vecs.push_back(mk(1,0,1,8'h00,5'd0,1,0, 8'h13,0,0,1,1));
        vecs.push_back(mk(1,0,0,8'h00,5'd0,1,0, 8'h13,0,0,0,0));
        // start beats enable; start/enable ignored in RUN and DONE
        vecs.push_back(mk(1,1,1,8'h40,5'd2,1,0, 8'h40,1,0,1,0));
        vecs.push_back(mk(1,1,1,8'h50,5'd3,0,0, 8'h40,1,0,1,0));
        vecs.push_back(mk(1,1,1,8'h50,5'd3,1,0, 8'h41,1,1,1,0));
        vecs.push_back(mk(1,1,1,8'h60,5'd2,1,0, 8'h41,0,0,1,1));
        vecs.push_back(mk(1,0,0,8'h00,5'd0,1,0, 8'h41,0,0,0,0));
        // backpressure 1,0,0,1,1
        vecs.push_back(mk(1,0,1,8'h80,5'd3,1,0, 8'h80,1,0,1,0));
        vecs.push_back(mk(1,0,0,8'h00,5'd0,1,0, 8'h81,1,0,1,0));
        vecs.push_back(mk(1,0,0,8'h00,5'd0,0,0, 8'h81,1,0,1,0));
        vecs.push_back(mk(1,0,0,8'h00,5'd0,0,0, 8'h81,1,0,1,0));
        vecs.push_back(mk(1,0,0,8'h00,5'd0,1,0, 8'h82,1,1,1,0));
        vecs.push_back(mk(1,0,0,8'h00,5'd0,1,0, 8'h82,0,0,1,1));
        vecs.push_back(mk(1,0,0,8'h00,5'd0,1,0, 8'h82,0,0,0,0));
        // abort on third beat
        vecs.push_back(mk(1,0,1,8'hA0,5'd8,1,0, 8'hA0,1,0,1,0));
        vecs.push_back(mk(1,0,0,8'h00,5'd0,1,0, 8'hA1,1,0,1,0));
        vecs.push_back(mk(1,0,0,8'h00,5'd0,1,0, 8'hA2,1,0,1,0));
        vecs.push_back(mk(1,0,0,8'h00,5'd0,1,1, 8'hA2,0,0,1,1));
        vecs.push_back(mk(1,0,0,8'h00,5'd0,1,0, 8'hA2,0,0,0,0));
        // reset mid-burst: no done pulse
        vecs.push_back(mk(1,0,1,8'hC0,5'd5,1,0, 8'hC0,1,0,1,0));
        vecs.push_back(mk(1,0,0,8'h00,5'd0,1,0, 8'hC1,1,0,1,0));
        vecs.push_back(mk(0,0,0,8'h00,5'd0,1,0, 8'hFF,0,0,0,0));
        vecs.push_back(mk(1,0,0,8'h00,5'd0,1,0, 8'hFF,0,0,0,0));

        for (int i = 0; i < vecs.size(); i++) begin
            drive1(vecs[i]);
            step();
            chk($sformatf("vec%0d addr", i),  int'(if1.addr_o),  int'(vecs[i].e_addr));
            chk($sformatf("vec%0d valid", i), int'(if1.valid_o), int'(vecs[i].e_valid));
            chk($sformatf("vec%0d last", i),  int'(if1.last_o),  int'(vecs[i].e_last));
            chk($sformatf("vec%0d busy", i),  int'(if1.busy_o),  int'(vecs[i].e_busy));
            chk($sformatf("vec%0d done", i),  int'(if1.done_o),  int'(vecs[i].e_done));
        end

        // STRIDE=4 burst inside window 0x20..0x2F: 28,2C,20,24
        s4_addr = '{8'h28, 8'h2C, 8'h20, 8'h24, 8'h24, 8'h24};
        // {valid, last, busy, done}
        s4_flags = '{'{1,0,1,0}, '{1,0,1,0}, '{1,0,1,0}, '{1,1,1,0}, '{0,0,1,1}, '{0,0,0,0}};
        if1.start_i = 0; if1.enable_i = 0; if1.abort_i = 0;
        if4.start_i = 1; if4.base_i = 8'h28; if4.count_i = 5'd4; if4.ready_i = 1;
        done_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if4.start_i = 0;
            if (if4.done_o) done_cnt++;
            chk($sformatf("s4 beat%0d addr", i), int'(if4.addr_o),  int'(s4_addr[i]));
            chk($sformatf("s4 beat%0d valid", i), int'(if4.valid_o), int'(s4_flags[i][0]));
            chk($sformatf("s4 beat%0d last", i),  int'(if4.last_o),  int'(s4_flags[i][1]));
            chk($sformatf("s4 beat%0d busy", i),  int'(if4.busy_o),  int'(s4_flags[i][2]));
            chk($sformatf("s4 beat%0d done", i),  int'(if4.done_o),  int'(s4_flags[i][3]));
        end
        chk("s4 done pulses", done_cnt, 1);

        // random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            rst_n        = ($urandom_range(0, 199) != 0);
            if1.enable_i = $urandom_range(0, 1) == 1;
            if1.start_i  = $urandom_range(0, 7) == 0;
            if1.base_i   = 8'($urandom_range(0, 255));
            if1.count_i  = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            if1.ready_i  = $urandom_range(0, 9) < 7;
            if1.abort_i  = $urandom_range(0, 39) == 0;
            if (mq.size() == 0 && !m_done && $urandom_range(0, 3) == 0) begin
                if1.wrap_lo_i = 8'($urandom_range(0, 255));
                if1.wrap_hi_i = 8'($urandom_range(0, 255));
            end
            step();
            check_model($sformatf("rnd%0d", c));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
